// File: rtl/twid_fetch.sv
// rtl/twid_fetch.sv - radix-4 twiddle ROM sequencer feeding the butterfly datapath
module twid_fetch #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        stage,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [5:0]        tw_idx,
  output logic [DATA_W-1:0] tw1_re,
  output logic [DATA_W-1:0] tw1_im,
  output logic [DATA_W-1:0] tw2_re,
  output logic [DATA_W-1:0] tw2_im,
  output logic [DATA_W-1:0] tw3_re,
  output logic [DATA_W-1:0] tw3_im
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_PRES  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // Latched per-stage context; the pointer walks base+6k+j without a multiplier
  logic [ADDR_W-1:0]   r_ptr;
  logic [6:0]          r_cnt;
  logic [5:0]          r_k;
  logic [2:0]          r_j;
  logic                r_err;

  logic [DATA_W-1:0]   r_tw1_re;
  logic [DATA_W-1:0]   r_tw1_im;
  logic [DATA_W-1:0]   r_tw2_re;
  logic [DATA_W-1:0]   r_tw2_im;
  logic [DATA_W-1:0]   r_tw3_re;
  logic [DATA_W-1:0]   r_tw3_im;

  logic                w_accept;
  logic                w_illegal;
  logic                w_last;
  logic                w_busy;
  logic                w_done;
  logic                w_rom_en;
  logic                w_tw_valid;
  logic [ADDR_W-1:0]   w_base_sel;
  logic [6:0]          w_cnt_sel;
  logic                w_cap_en;
  logic [2:0]          w_cap_sel;

  // Stage decode: ROM base offset and number of butterfly indices
  always_comb begin
    w_base_sel = '0;
    w_cnt_sel  = 7'd0;
    case (stage)
      2'd0: begin w_base_sel = ADDR_W'(0);   w_cnt_sel = 7'd4;  end
      2'd1: begin w_base_sel = ADDR_W'(24);  w_cnt_sel = 7'd16; end
      2'd2: begin w_base_sel = ADDR_W'(120); w_cnt_sel = 7'd64; end
      default: begin w_base_sel = '0; w_cnt_sel = 7'd0; end
    endcase
  end

  assign w_last = ({1'b0, r_k} == (r_cnt - 7'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control outputs; ROM is only read in FETCH so a stalled PRES loses nothing
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_illegal  = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_rom_en   = 1'b0;
    w_tw_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (stage != 2'd3) begin
            w_accept = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_FETCH: begin
        w_busy   = 1'b1;
        w_rom_en = 1'b1;
        if (r_j == 3'd5) begin
          w_next = S_CAPT;
        end
      end
      S_CAPT: begin
        w_busy = 1'b1;
        w_next = S_PRES;
      end
      S_PRES: begin
        w_busy     = 1'b1;
        w_tw_valid = 1'b1;
        if (tw_ready) begin
          w_next = w_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Word j-1 arrives while word j is addressed; the final word lands in CAPT
  assign w_cap_en  = ((r_state == S_FETCH) && (r_j != 3'd0)) || (r_state == S_CAPT);
  assign w_cap_sel = (r_state == S_CAPT) ? 3'd5 : (r_j - 3'd1);

  // Sequencing counters, address pointer and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= 7'd0;
      r_k   <= 6'd0;
      r_j   <= 3'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_accept) begin
        r_ptr <= w_base_sel;
        r_cnt <= w_cnt_sel;
        r_k   <= 6'd0;
        r_j   <= 3'd0;
      end else if (r_state == S_FETCH) begin
        r_ptr <= r_ptr + ADDR_W'(1);
        r_j   <= (r_j == 3'd5) ? 3'd0 : (r_j + 3'd1);
      end else if ((r_state == S_PRES) && tw_ready && !w_last) begin
        r_k <= r_k + 6'd1;
      end
    end
  end

  // Twiddle capture registers; held untouched through PRES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tw1_re <= '0;
      r_tw1_im <= '0;
      r_tw2_re <= '0;
      r_tw2_im <= '0;
      r_tw3_re <= '0;
      r_tw3_im <= '0;
    end else if (w_cap_en) begin
      case (w_cap_sel)
        3'd0:    r_tw1_re <= rom_dout;
        3'd1:    r_tw1_im <= rom_dout;
        3'd2:    r_tw2_re <= rom_dout;
        3'd3:    r_tw2_im <= rom_dout;
        3'd4:    r_tw3_re <= rom_dout;
        default: r_tw3_im <= rom_dout;
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign err      = r_err;
  assign rom_en   = w_rom_en;
  assign rom_addr = (r_state == S_FETCH) ? r_ptr : '0;
  assign tw_valid = w_tw_valid;
  assign tw_idx   = r_k;
  assign tw1_re   = r_tw1_re;
  assign tw1_im   = r_tw1_im;
  assign tw2_re   = r_tw2_re;
  assign tw2_im   = r_tw2_im;
  assign tw3_re   = r_tw3_re;
  assign tw3_im   = r_tw3_im;

endmodule

// File: tb/tb_twid_fetch.sv
// tb/tb_twid_fetch.sv - self-checking bench for twid_fetch
module tb_twid_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  stage;
  logic        busy, done, err, rom_en, tw_valid, tw_ready;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic [5:0]  tw_idx;
  logic [31:0] tw1_re, tw1_im, tw2_re, tw2_im, tw3_re, tw3_im;

  twid_fetch #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage),
    .busy(busy), .done(done), .err(err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_idx(tw_idx),
    .tw1_re(tw1_re), .tw1_im(tw1_im), .tw2_re(tw2_re),
    .tw2_im(tw2_im), .tw3_re(tw3_re), .tw3_im(tw3_im)
  );

  typedef struct packed {
    logic [5:0]       idx;
    logic [5:0][31:0] w;
  } set_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_sets = 0;
  int          n_done = 0;
  int          max_addr = 0;
  int          ncyc, first_valid, stall, wv, n_err, done_before;
  set_t        exp_q[$];
  int          addr_q[$];
  logic [31:0] rom [0:1023];
  logic [31:0] got_w [0:63][0:5];
  logic [197:0] p_vec;
  logic        p_valid = 1'b0;
  logic        p_hs = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom[rom_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_stage(input int st);
    int base, cnt;
    set_t s;
    base = (st == 0) ? 0 : (st == 1) ? 24 : 120;
    cnt  = (st == 0) ? 4 : (st == 1) ? 16 : 64;
    for (int k = 0; k < cnt; k++) begin
      s.idx = 6'(k);
      for (int j = 0; j < 6; j++) begin
        addr_q.push_back(base + 6 * k + j);
        s.w[j] = rom[base + 6 * k + j];
      end
      exp_q.push_back(s);
    end
  endtask

  task automatic pulse_start(input logic [1:0] st);
    @(posedge clk); #1;
    start = 1'b1;
    stage = st;
    @(posedge clk); #1;
    start = 1'b0;
    stage = 2'd0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check({tag, "_done_seen"}, 64'(i < max), 64'd1);
  endtask

  task automatic check_set(input string tag, input int k, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] a4,
                           input logic [31:0] a5);
    check({tag, "_tw1_re"}, 64'(got_w[k][0]), 64'(a0));
    check({tag, "_tw1_im"}, 64'(got_w[k][1]), 64'(a1));
    check({tag, "_tw2_re"}, 64'(got_w[k][2]), 64'(a2));
    check({tag, "_tw2_im"}, 64'(got_w[k][3]), 64'(a3));
    check({tag, "_tw3_re"}, 64'(got_w[k][4]), 64'(a4));
    check({tag, "_tw3_im"}, 64'(got_w[k][5]), 64'(a5));
  endtask

  // Scoreboard monitor: ROM address order, no reads while presenting, stability under stall, set contents
  always @(negedge clk) begin
    logic [197:0] cur;
    set_t e;
    cur = {tw_idx, tw1_re, tw1_im, tw2_re, tw2_im, tw3_re, tw3_im};
    if (!rst_n) begin
      p_valid = 1'b0;
      p_hs = 1'b0;
    end else begin
      if (done === 1'b1) n_done++;
      if (rom_en === 1'b1) begin
        if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        if (addr_q.size() == 0) check("unexpected_rom_read", 64'(rom_addr), 64'hffff);
        else check("rom_addr", 64'(rom_addr), 64'(addr_q.pop_front()));
      end
      if (tw_valid === 1'b1) check("rom_en_in_pres", 64'(rom_en), 64'd0);
      if (tw_valid === 1'b1 && p_valid && !p_hs)
        check("stable_while_stalled", 64'(cur === p_vec), 64'd1);
      if (tw_valid === 1'b1 && tw_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_set", 64'(tw_idx), 64'hff);
        end else begin
          e = exp_q.pop_front();
          check("set_idx", 64'(tw_idx), 64'(e.idx));
          check("set_tw1_re", 64'(tw1_re), 64'(e.w[0]));
          check("set_tw1_im", 64'(tw1_im), 64'(e.w[1]));
          check("set_tw2_re", 64'(tw2_re), 64'(e.w[2]));
          check("set_tw2_im", 64'(tw2_im), 64'(e.w[3]));
          check("set_tw3_re", 64'(tw3_re), 64'(e.w[4]));
          check("set_tw3_im", 64'(tw3_im), 64'(e.w[5]));
        end
        got_w[tw_idx][0] = tw1_re; got_w[tw_idx][1] = tw1_im;
        got_w[tw_idx][2] = tw2_re; got_w[tw_idx][3] = tw2_im;
        got_w[tw_idx][4] = tw3_re; got_w[tw_idx][5] = tw3_im;
        n_sets++;
      end
      p_valid = (tw_valid === 1'b1);
      p_hs = (tw_valid === 1'b1) && (tw_ready === 1'b1);
      p_vec = cur;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h9e3779b9 * (i + 1) ^ 32'h5bd1e995;
    rom[6]   = 32'h5a82799a; rom[7]   = 32'hd2bec333; rom[8]   = 32'h539eba45;
    rom[9]   = 32'he7821d59; rom[10]  = 32'h539eba45; rom[11]  = 32'hc4df2862;
    rom[30]  = 32'h4b418bbe; rom[31]  = 32'hf383a3e2; rom[32]  = 32'h45f704f7;
    rom[33]  = 32'hf9ba1651; rom[34]  = 32'h4fd288dc; rom[35]  = 32'hed6bf9d1;
    rom[498] = 32'hc337a8f7; rom[499] = 32'hfcdc1342; rom[500] = 32'h418d2621;
    rom[501] = 32'hc004ef3f; rom[502] = 32'hbb771c81; rom[503] = 32'h3fd39b5a;

    rst_n = 1'b0; start = 1'b0; stage = 2'd0; tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({busy, done, err, rom_en, tw_valid, tw_idx, rom_addr}), 64'd0);
    check("reset_tw", 64'(|{tw1_re, tw1_im, tw2_re, tw2_im, tw3_re, tw3_im}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Stage 0 with tw_ready held high: timing, 4 sets, k=1 contents
    tw_ready = 1'b1;
    n_sets = 0;
    push_stage(0);
    @(posedge clk); #1;
    start = 1'b1; stage = 2'd0;
    ncyc = 1; first_valid = 0;
    @(negedge clk);
    check("s0_busy_start_cycle", 64'({busy, rom_en}), 64'd0);
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 2) check("s0_first_fetch", 64'({busy, rom_en, rom_addr}), 64'({1'b1, 1'b1, 10'd0}));
      if (tw_valid === 1'b1 && first_valid == 0) first_valid = ncyc;
      if (done === 1'b1) break;
    end
    check("s0_first_valid_cycle", 64'(first_valid), 64'd9);
    check("s0_done_cycle", 64'(ncyc), 64'd34);
    check("s0_busy_low_at_done", 64'(busy), 64'd0);
    check("s0_sets", 64'(n_sets), 64'd4);
    check_set("s0_k1", 1, 32'h5a82799a, 32'hd2bec333, 32'h539eba45, 32'he7821d59, 32'h539eba45, 32'hc4df2862);

    // Illegal stage: err pulse, no busy, no reads
    n_err = 0;
    pulse_start(2'd3);
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge clk);
      else #4;
      if (err === 1'b1) n_err++;
      check("illegal_idle", 64'({busy, rom_en}), 64'd0);
    end
    check("illegal_err_pulses", 64'(n_err), 64'd1);

    // Stage 1 abandoned by reset mid-FETCH
    done_before = n_done;
    push_stage(1);
    pulse_start(2'd1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({busy, done, err, rom_en, tw_valid, tw_idx, rom_addr}), 64'd0);
    check("midrst_tw", 64'(|{tw1_re, tw1_im, tw2_re, tw2_im, tw3_re, tw3_im}), 64'd0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(n_done), 64'(done_before));

    // Stage 1 fresh run with an ignored start, then back-to-back stage 0
    n_sets = 0;
    push_stage(1);
    pulse_start(2'd1);
    repeat (20) @(posedge clk);
    #1 start = 1'b1; stage = 2'd2;
    @(posedge clk); #1 start = 1'b0; stage = 2'd0;
    wait_done("s1", 300);
    check("s1_sets", 64'(n_sets), 64'd16);
    check_set("s1_k1", 1, 32'h4b418bbe, 32'hf383a3e2, 32'h45f704f7, 32'hf9ba1651, 32'h4fd288dc, 32'hed6bf9d1);
    n_sets = 0;
    push_stage(0);
    @(posedge clk); #1 start = 1'b1; stage = 2'd0;
    @(posedge clk); #1 start = 1'b0;
    check("b2b_accepted_busy", 64'(busy), 64'd1);
    wait_done("b2b", 100);
    check("b2b_sets", 64'(n_sets), 64'd4);

    // Stage 2 with random consumer stalls
    tw_ready = 1'b0;
    n_sets = 0;
    max_addr = 0;
    push_stage(2);
    pulse_start(2'd2);
    for (int k = 0; k < 64; k++) begin
      stall = $urandom_range(0, 10);
      wv = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (tw_valid === 1'b1) begin wv = 1; break; end
      end
      check("s2_valid_wait", 64'(wv), 64'd1);
      if (wv == 0) break;
      repeat (stall) @(negedge clk);
      @(posedge clk); #1 tw_ready = 1'b1;
      @(posedge clk); #1 tw_ready = 1'b0;
    end
    wait_done("s2", 20);
    check("s2_sets", 64'(n_sets), 64'd64);
    check_set("s2_k63", 63, 32'hc337a8f7, 32'hfcdc1342, 32'h418d2621, 32'hc004ef3f, 32'hbb771c81, 32'h3fd39b5a);
    check("s2_max_addr", 64'(max_addr), 64'd503);

    repeat (3) @(negedge clk);
    check("sb_sets_drained", 64'(exp_q.size()), 64'd0);
    check("sb_addrs_drained", 64'(addr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
